// File: rtl/ble_cmd_queue.sv
// In-order command FIFO between the BLE UART wrapper and the command processor.
// Both sides use a level-ready / pulse-clear handshake.
module ble_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CMD_W-1:0]       in_cmd,
  input  logic                   in_rdy,
  output logic                   in_clr,
  input  logic                   flush,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][CMD_W-1:0] r_mem;
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic                        r_in_clr;
  logic                        w_push;
  logic                        w_pop;

  assign cmd     = r_mem[r_rd_ptr];
  assign cmd_rdy = (r_count != '0);
  assign full    = (r_count == CW'(DEPTH));
  assign count   = r_count;
  assign in_clr  = r_in_clr;

  // ~r_in_clr stops a second capture while the wrapper is still lowering in_rdy;
  // push is judged against full before any same-cycle pop.
  assign w_push = in_rdy & ~full & ~r_in_clr & ~flush;
  assign w_pop  = clr_cmd_rdy & cmd_rdy & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_in_clr <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_in_clr <= 1'b0;
    end else begin
      r_in_clr <= w_push;
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_cmd;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_ble_cmd_queue.sv
// Directed bench for ble_cmd_queue; inputs driven and outputs sampled 1ns after posedge.
module tb_ble_cmd_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_cmd;
  logic        in_rdy;
  logic        in_clr;
  logic        flush;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [2:0]  count;
  logic        full;

  int n_chk  = 0;
  int n_fail = 0;

  ble_cmd_queue #(.DEPTH(4), .CMD_W(16)) dut (
    .clk(clk), .rst(rst), .in_cmd(in_cmd), .in_rdy(in_rdy), .in_clr(in_clr),
    .flush(flush), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wrapper-style push: hold in_rdy until in_clr is seen, then drop it
  task automatic push(input logic [15:0] v);
    in_cmd = v;
    in_rdy = 1'b1;
    step();
    chk("push_clr", in_clr, 1);
    in_rdy = 1'b0;
    step();
    chk("push_clr_low", in_clr, 0);
  endtask

  task automatic pop();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_cmd = '0; in_rdy = 1'b0; flush = 1'b0; clr_cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (10) step();
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_in_clr", in_clr, 0);
    chk("rst_cmd", cmd, 16'h0000);

    // single command, in_rdy held one cycle past in_clr
    in_cmd = 16'h2F01; in_rdy = 1'b1;
    step();
    chk("t2_clr", in_clr, 1);
    chk("t2_rdy", cmd_rdy, 1);
    chk("t2_cmd", cmd, 16'h2F01);
    chk("t2_cnt", count, 1);
    step();
    in_rdy = 1'b0;
    chk("t2_one_pulse", in_clr, 0);
    chk("t2_cnt_hold", count, 1);
    pop();
    chk("t2_pop_cnt", count, 0);
    chk("t2_pop_rdy", cmd_rdy, 0);

    // fill, then back-pressure
    for (int i = 0; i < 4; i++) push(16'h4000 + 16'(i));
    chk("t3_full", full, 1);
    chk("t3_cnt", count, 4);
    chk("t3_head", cmd, 16'h4000);
    in_cmd = 16'h4004; in_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_no_clr", in_clr, 0);
      chk("t3_cnt_full", count, 4);
    end
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    chk("t3_pop_head", cmd, 16'h4001);
    chk("t3_pop_cnt", count, 3);
    chk("t3_pop_noclr", in_clr, 0);
    step();
    chk("t3_late_clr", in_clr, 1);
    chk("t3_refill", count, 4);
    in_rdy = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain", cmd, 16'h4000 + 16'(i));
      pop();
    end
    chk("t3_empty", count, 0);

    // wrap-around
    for (int i = 0; i < 10; i++) begin
      push(16'h3000 + 16'(i));
      chk("t4_cmd", cmd, 16'h3000 + 16'(i));
      chk("t4_cnt", count, 1);
      pop();
      chk("t4_empty", count, 0);
    end

    // simultaneous push and pop at count 2
    push(16'hA000);
    push(16'hA001);
    chk("t5_cnt2", count, 2);
    in_cmd = 16'hA002; in_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    step();
    in_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    chk("t5_cnt", count, 2);
    chk("t5_head", cmd, 16'hA001);
    chk("t5_clr", in_clr, 1);
    step();
    pop();
    chk("t5_next", cmd, 16'hA002);
    pop();
    chk("t5_empty", count, 0);

    // flush with pending in_rdy
    push(16'hB000); push(16'hB001); push(16'hB002);
    chk("t6_cnt3", count, 3);
    in_cmd = 16'hBEEF; in_rdy = 1'b1; flush = 1'b1;
    chk("t6_flush_noclr", in_clr, 0);
    step();
    flush = 1'b0;
    chk("t6_cnt0", count, 0);
    chk("t6_rdy0", cmd_rdy, 0);
    chk("t6_noclr", in_clr, 0);
    step();
    chk("t6_capture", count, 1);
    chk("t6_cmd", cmd, 16'hBEEF);
    chk("t6_clr", in_clr, 1);
    in_rdy = 1'b0;
    step();
    pop();
    chk("t6_empty", count, 0);

    // pop while empty
    for (int i = 0; i < 3; i++) begin
      pop();
      chk("t7_cnt", count, 0);
      chk("t7_rdy", cmd_rdy, 0);
    end

    // async reset mid-drain while in_clr is high
    push(16'hC000); push(16'hC001); push(16'hC002);
    pop();
    chk("t8_head", cmd, 16'hC001);
    in_cmd = 16'hC003; in_rdy = 1'b1;
    step();
    chk("t8_clr_pre", in_clr, 1);
    #2 rst = 1'b1;
    #1;
    chk("t8_cnt", count, 0);
    chk("t8_rdy", cmd_rdy, 0);
    chk("t8_full", full, 0);
    chk("t8_cmd", cmd, 16'h0000);
    chk("t8_clr", in_clr, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("t8_recap_cnt", count, 1);
    chk("t8_recap_cmd", cmd, 16'hC003);
    chk("t8_recap_clr", in_clr, 1);
    in_rdy = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ble_cmd_queue.md
Name: ble_cmd_queue

Overview:
- Command queue between the BLE UART wrapper and the command mux/command processor of the Knight's Tour robot.
- Accepts 16-bit commands from the UART wrapper's cmd_rdy/clr_cmd_rdy handshake and holds up to DEPTH of them in order.
- Presents the head command downstream with the same level-ready / pulse-clear handshake, so commands sent while a move is executing are not lost.

Parameters:
- DEPTH, 4, number of command entries; power of 2, minimum 2.
- CMD_W, 16, command width in bits.

Ports:
- clk  in  1  system clock, 50MHz.
- rst  in  1  asynchronous active-high reset.
- in_cmd  in  CMD_W  command from UART wrapper; valid while in_rdy is high.
- in_rdy  in  1  level; UART wrapper holds a command.
- in_clr  out  1  one-cycle pulse; command captured, UART wrapper drops in_rdy.
- flush  in  1  synchronous clear of all queued entries (abort / new tour).
- cmd  out  CMD_W  head-of-queue command.
- cmd_rdy  out  1  level; queue not empty.
- clr_cmd_rdy  in  1  one-cycle pulse from consumer; pop head.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage entries =0, so cmd=0.
  - in_clr=0, cmd_rdy=0, full=0.
- Storage: DEPTH x CMD_W register array, circular, with wr_ptr and rd_ptr of width $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0.
- Push condition (cycle N): in_rdy & ~full & ~in_clr & ~flush.
  - At the edge ending cycle N: mem[wr_ptr]<=in_cmd, wr_ptr++, in_clr<=1.
  - in_clr is therefore high in cycle N+1 only.
  - The ~in_clr term blocks a second capture of the same command while the wrapper lowers in_rdy.
- in_clr is a registered output and is never high two consecutive cycles.
- Pop condition: clr_cmd_rdy & cmd_rdy & ~flush. At the edge, rd_ptr++.
  - clr_cmd_rdy while empty is ignored; no pointer or count change.
- Outputs are combinational from registers:
  - cmd = mem[rd_ptr].
  - cmd_rdy = (count != 0).
  - full = (count == DEPTH).
  - Latency in_rdy -> cmd_rdy is 1 cycle when the queue was empty.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop in the same cycle (both pointers advance).
- Full: the push is evaluated against full before the pop. When full, a same-cycle pop does not enable a push. The push occurs the next cycle, while the wrapper holds in_rdy. No command is ever dropped; back-pressure is via the withheld in_clr.
- Flush has priority over push and pop:
  - At the edge: wr_ptr=rd_ptr=0, count=0, in_clr<=0.
  - Storage contents are unchanged.
  - cmd_rdy drops the cycle after flush is sampled.
  - A pending in_rdy is captured at the earliest cycle after flush deasserts.
- A pop never alters storage; cmd shows the next entry one cycle after a pop.
- An async reset mid-handshake clears in_clr immediately. The wrapper's held command is then re-captured after reset releases.

Test Plan:
- Reset, then idle 10 cycles -> cmd_rdy=0, full=0, count=0, in_clr=0, cmd=16'h0000.
- in_cmd=16'h2F01, in_rdy high until in_clr seen plus 1 cycle -> exactly one in_clr pulse; the next cycle has cmd_rdy=1, cmd=16'h2F01, count=1. Then pulse clr_cmd_rdy -> count=0, cmd_rdy=0.
- Push 16'h4000, 16'h4001, 16'h4002, 16'h4003, then hold in_rdy with 16'h4004:
  - full=1, count=4, and no in_clr while full.
  - Pulse clr_cmd_rdy -> the head pop shows cmd=16'h4001 the next cycle.
  - Then in_clr pulses and count returns to 4.
  - Draining gives 4001, 4002, 4003, 4004 in order.
- Wrap-around: 10 single push/pop pairs of 16'h3000+i -> each cmd matches in order; pointers wrap without a stale or duplicated value.
- Simultaneous push and pop at count=2 -> count stays 2, and the head advances correctly.
- With count=3, assert flush for 1 cycle while in_rdy is high with 16'hBEEF:
  - The next cycle has count=0, cmd_rdy=0, and no in_clr during the flush cycle.
  - The following cycle captures 16'hBEEF, giving count=1.
- clr_cmd_rdy pulses while empty -> count stays 0, no underflow.
- Async reset asserted mid-drain -> all outputs return to their reset values immediately, without waiting for a clock edge.
